// File: rtl/tx_resp_fifo_pkg.sv
// Shared constants, state encodings and flag payload for the TX response FIFO.
package tx_resp_fifo_pkg;

    localparam int unsigned TXF_WIDTH   = 8;
    localparam int unsigned TXF_DEPTH   = 8;
    localparam int unsigned TXF_ACK_TMO = 15;

    localparam logic [1:0] TXF_IDLE      = 2'b00;
    localparam logic [1:0] TXF_WAIT_ACK  = 2'b01;
    localparam logic [1:0] TXF_WAIT_DONE = 2'b10;

    typedef struct packed {
        logic full;
        logic empty;
        logic overflow;
        logic ack_err;
    } txf_flags_t;

    localparam txf_flags_t TXF_FLAGS_RST = '{full: 1'b0, empty: 1'b1, overflow: 1'b0, ack_err: 1'b0};

endpackage

// File: rtl/tx_resp_fifo_if.sv
// Bus between the system controller / UART TX front end and the response FIFO.
interface tx_resp_fifo_if
    import tx_resp_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = TXF_WIDTH,
    parameter int unsigned DEPTH = TXF_DEPTH
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] wr_data;
    logic             wr_valid;
    logic             busy;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             ack_err;

    modport master (
        output wr_data, wr_valid, busy,
        input  tx_data, tx_valid, full, empty, count, overflow, ack_err
    );

    modport slave (
        input  wr_data, wr_valid, busy,
        output tx_data, tx_valid, full, empty, count, overflow, ack_err
    );

endinterface

// File: rtl/tx_resp_fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write, combinational read, no reset.
module tx_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/tx_resp_fifo.sv
// Response byte buffer feeding the UART TX with a valid-pulse / busy handshake.
module tx_resp_fifo
    import tx_resp_fifo_pkg::*;
#(
    parameter int unsigned WIDTH   = TXF_WIDTH,
    parameter int unsigned DEPTH   = TXF_DEPTH,
    parameter int unsigned ACK_TMO = TXF_ACK_TMO
) (
    input  logic         clk,
    input  logic         rst,
    tx_resp_fifo_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = (ACK_TMO < 1) ? 1 : $clog2(ACK_TMO + 1);

    logic [1:0]       state, state_nxt;
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic [TMO_W-1:0] tmo, tmo_nxt;
    logic [WIDTH-1:0] tx_data, tx_data_nxt, rd_data;
    logic             tx_valid, tx_valid_nxt;
    txf_flags_t       flags, flags_nxt;
    logic             pop, push;

    tx_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we      (push),
        .waddr   (wptr),
        .wdata   (bus.wr_data),
        .raddr   (rptr),
        .rdata_c (rd_data)
    );

    // Next-state, issue and occupancy logic
    always_comb begin
        state_nxt    = state;
        tmo_nxt      = tmo;
        tx_data_nxt  = tx_data;
        tx_valid_nxt = 1'b0;
        flags_nxt    = flags;
        pop          = 1'b0;
        count_nxt    = count;

        case (state)
            TXF_IDLE: begin
                if (!flags.empty && !bus.busy) begin
                    pop          = 1'b1;
                    tx_data_nxt  = rd_data;
                    tx_valid_nxt = 1'b1;
                    tmo_nxt      = '0;
                    state_nxt    = TXF_WAIT_ACK;
                end
            end
            TXF_WAIT_ACK: begin
                if (bus.busy) begin
                    state_nxt = TXF_WAIT_DONE;
                end else if (tmo == TMO_W'(ACK_TMO)) begin
                    flags_nxt.ack_err = 1'b1;
                    state_nxt         = TXF_IDLE;
                end else begin
                    tmo_nxt = tmo + TMO_W'(1);
                end
            end
            TXF_WAIT_DONE: begin
                if (!bus.busy) begin
                    state_nxt = TXF_IDLE;
                end
            end
            default: state_nxt = TXF_IDLE;
        endcase

        // A pop in the same cycle frees the slot a full-FIFO push needs
        push = bus.wr_valid && (!flags.full || pop);

        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase

        flags_nxt.full     = (count_nxt == CNT_W'(DEPTH));
        flags_nxt.empty    = (count_nxt == '0);
        flags_nxt.overflow = flags.overflow | (bus.wr_valid && !push);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TXF_IDLE;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            tmo      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            flags    <= TXF_FLAGS_RST;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            tmo      <= tmo_nxt;
            tx_data  <= tx_data_nxt;
            tx_valid <= tx_valid_nxt;
            flags    <= flags_nxt;
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
        end
    end

    assign bus.tx_data  = tx_data;
    assign bus.tx_valid = tx_valid;
    assign bus.full     = flags.full;
    assign bus.empty    = flags.empty;
    assign bus.count    = count;
    assign bus.overflow = flags.overflow;
    assign bus.ack_err  = flags.ack_err;

endmodule

// File: tb/tb_tx_resp_fifo.sv
// Directed scenario bench for tx_resp_fifo; inputs driven and outputs sampled on the falling edge.
module tb_tx_resp_fifo;
    import tx_resp_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    tx_resp_fifo_if bus ();

    tx_resp_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.busy     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_one(input logic [7:0] d);
        @(negedge clk);
        bus.wr_data  = d;
        bus.wr_valid = 1'b1;
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.wr_data  = base + 8'(i);
            bus.wr_valid = 1'b1;
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    // Wait (bounded) for an issue pulse, capture the byte, then ack with 2 cycles of busy
    task automatic wait_issue_ack(output logic [7:0] d, output bit got);
        got = 1'b0;
        d   = 8'h00;
        for (int i = 0; i < 40 && !got; i++) begin
            if (bus.tx_valid === 1'b1) begin
                got = 1'b1;
                d   = bus.tx_data;
            end else begin
                @(negedge clk);
            end
        end
        if (got) begin
            bus.busy = 1'b1;
            @(negedge clk);
            @(negedge clk);
            bus.busy = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.tx_data, bus.tx_valid, bus.full, bus.empty, bus.count, bus.overflow, bus.ack_err}
            !== {8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got data=%h v=%b f=%b e=%b cnt=%0d ovf=%b ackerr=%b, exp 00 0 0 1 0 0 0",
                     bus.tx_data, bus.tx_valid, bus.full, bus.empty, bus.count, bus.overflow, bus.ack_err);
        end
    endtask

    task automatic test_basic();
        do_reset();
        push_one(8'hA5);
        checks++;
        if ({bus.tx_valid, bus.count} !== {1'b0, 4'd1}) begin
            errors++;
            $display("FAIL basic_after_push: got v=%b cnt=%0d, exp v=0 cnt=1", bus.tx_valid, bus.count);
        end
        @(negedge clk);
        checks++;
        if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL basic_issue: got v=%b data=%h, exp v=1 data=a5", bus.tx_valid, bus.tx_data);
        end
        bus.busy = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse_width: got v=%b, exp 0", bus.tx_valid);
        end
        @(negedge clk);
        bus.busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.empty, bus.count, bus.tx_valid, bus.tx_data} !== {1'b1, 4'd0, 1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL basic_idle: got e=%b cnt=%0d v=%b data=%h, exp e=1 cnt=0 v=0 data=a5",
                     bus.empty, bus.count, bus.tx_valid, bus.tx_data);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        bit         got;
        bit         seen;
        do_reset();
        bus.busy = 1'b1;
        fill(8'h11, 8);
        checks++;
        if ({bus.full, bus.count, bus.overflow} !== {1'b1, 4'd8, 1'b0}) begin
            errors++;
            $display("FAIL ovf_fill: got f=%b cnt=%0d ovf=%b, exp f=1 cnt=8 ovf=0", bus.full, bus.count, bus.overflow);
        end
        push_one(8'h99);
        checks++;
        if ({bus.full, bus.count, bus.overflow} !== {1'b1, 4'd8, 1'b1}) begin
            errors++;
            $display("FAIL ovf_drop: got f=%b cnt=%0d ovf=%b, exp f=1 cnt=8 ovf=1", bus.full, bus.count, bus.overflow);
        end
        bus.busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_issue_ack(d, got);
            checks++;
            if (!got || d !== 8'h11 + 8'(i)) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: got issued=%b data=%h, exp data=%h", i, got, d, 8'h11 + 8'(i));
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen |= (bus.tx_valid === 1'b1);
        end
        checks++;
        if ({seen, bus.empty, bus.overflow} !== {1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovf_no_extra: got extra_issue=%b e=%b ovf=%b, exp 0 1 1", seen, bus.empty, bus.overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] d;
        logic [7:0] exp;
        bit         got;
        do_reset();
        bus.busy = 1'b1;
        fill(8'h21, 8);
        @(negedge clk);
        bus.busy     = 1'b0;
        bus.wr_data  = 8'h55;
        bus.wr_valid = 1'b1;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        checks++;
        if ({bus.tx_valid, bus.tx_data, bus.count, bus.full, bus.overflow} !== {1'b1, 8'h21, 4'd8, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fpp_accept: got v=%b data=%h cnt=%0d f=%b ovf=%b, exp 1 21 8 1 0",
                     bus.tx_valid, bus.tx_data, bus.count, bus.full, bus.overflow);
        end
        for (int i = 0; i < 9; i++) begin
            exp = (i < 8) ? 8'h21 + 8'(i) : 8'h55;
            wait_issue_ack(d, got);
            checks++;
            if (!got || d !== exp) begin
                errors++;
                $display("FAIL fpp_drain[%0d]: got issued=%b data=%h, exp data=%h", i, got, d, exp);
            end
        end
        checks++;
        if ({bus.empty, bus.overflow} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fpp_end: got e=%b ovf=%b, exp e=1 ovf=0", bus.empty, bus.overflow);
        end
    endtask

    task automatic test_ack_timeout();
        logic [7:0] d;
        bit         got;
        do_reset();
        push_one(8'h3C);
        @(negedge clk);
        checks++;
        if ({bus.tx_valid, bus.tx_data, bus.ack_err} !== {1'b1, 8'h3C, 1'b0}) begin
            errors++;
            $display("FAIL tmo_issue: got v=%b data=%h ackerr=%b, exp 1 3c 0", bus.tx_valid, bus.tx_data, bus.ack_err);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (bus.ack_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_early: got ackerr=%b after 15 wait cycles, exp 0", bus.ack_err);
        end
        @(negedge clk);
        checks++;
        if ({bus.ack_err, bus.empty, bus.tx_valid} !== {1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL tmo_expire: got ackerr=%b e=%b v=%b, exp 1 1 0", bus.ack_err, bus.empty, bus.tx_valid);
        end
        push_one(8'h4D);
        wait_issue_ack(d, got);
        checks++;
        if (!got || d !== 8'h4D || bus.ack_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_recover: got issued=%b data=%h ackerr=%b, exp data=4d ackerr=1", got, d, bus.ack_err);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        bus.busy = 1'b1;
        fill(8'h61, 3);
        @(negedge clk);
        bus.busy = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.tx_valid, bus.tx_data, bus.count} !== {1'b1, 8'h61, 4'd2}) begin
            errors++;
            $display("FAIL rmid_issue: got v=%b data=%h cnt=%0d, exp 1 61 2", bus.tx_valid, bus.tx_data, bus.count);
        end
        bus.busy = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.count, bus.empty, bus.full, bus.tx_valid, bus.overflow, bus.ack_err}
            !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rmid_clear: got cnt=%0d e=%b f=%b v=%b ovf=%b ackerr=%b, exp 0 1 0 0 0 0",
                     bus.count, bus.empty, bus.full, bus.tx_valid, bus.overflow, bus.ack_err);
        end
        rst      = 1'b0;
        bus.busy = 1'b0;
        seen     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen |= (bus.tx_valid === 1'b1);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rmid_discard: got issue after reset=%b, exp 0", seen);
        end
    endtask

    task automatic test_wrap();
        int         push_n [4] = '{6, 6, 6, 2};
        int         drain_n[4] = '{4, 6, 8, 2};
        logic [7:0] q[$];
        logic [7:0] nxt = 8'h80;
        logic [7:0] d;
        logic [7:0] exp;
        bit         got;
        int         model_cnt = 0;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            bus.busy = 1'b1;
            for (int i = 0; i < push_n[p]; i++) begin
                @(negedge clk);
                bus.wr_data  = nxt;
                bus.wr_valid = 1'b1;
                q.push_back(nxt);
                nxt++;
                model_cnt++;
            end
            @(negedge clk);
            bus.wr_valid = 1'b0;
            checks++;
            if (bus.count !== 4'(model_cnt)) begin
                errors++;
                $display("FAIL wrap_count_push[%0d]: got cnt=%0d, exp %0d", p, bus.count, model_cnt);
            end
            bus.busy = 1'b0;
            for (int i = 0; i < drain_n[p]; i++) begin
                exp = q.pop_front();
                model_cnt--;
                wait_issue_ack(d, got);
                checks++;
                if (!got || d !== exp) begin
                    errors++;
                    $display("FAIL wrap_data[%0d.%0d]: got issued=%b data=%h, exp %h", p, i, got, d, exp);
                end
            end
            checks++;
            if (bus.count !== 4'(model_cnt)) begin
                errors++;
                $display("FAIL wrap_count_drain[%0d]: got cnt=%0d, exp %0d", p, bus.count, model_cnt);
            end
        end
        checks++;
        if ({bus.empty, bus.overflow} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap_end: got e=%b ovf=%b, exp 1 0", bus.empty, bus.overflow);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.busy     = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_ack_timeout();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
